four_bit_sub_serial: RTL



---
 rtl/sub_pkg.sv | 13 +
 rtl/full_sub_cell.sv | 14 +
 rtl/four_bit_sub_serial.sv | 93 +++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, with the borrow produced toward
// the next more significant stage.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/four_bit_sub_serial.sv
// Bit-serial subtractor: out = in1 - in2 (mod 2^WIDTH), one bit per clock,
// LSB first, with start/busy/done handshake and a per-stage borrow vector.
module four_bit_sub_serial
  import sub_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] borrow
);

  state_t           state;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [CNT_W-1:0] idx;
  logic             bin;

  logic             cell_d;
  logic             cell_bout;
  logic [WIDTH-1:0] bit_mask;
  logic             accept;
  logic             last_bit;

  full_sub_cell u_cell (
    .a    (op1[0]),
    .b    (op2[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // A mask rather than out[idx] keeps the index width independent of WIDTH.
  assign bit_mask = WIDTH'(1) << idx;
  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (idx == CNT_W'(WIDTH - 1));

  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking assignments would make the result
  // depend on statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op1    <= '0;
      op2    <= '0;
      idx    <= '0;
      bin    <= 1'b0;
      out    <= '0;
      borrow <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op1    <= in1;
        op2    <= in2;
        idx    <= '0;
        bin    <= 1'b0;
        out    <= '0;
        borrow <= '0;
        busy   <= 1'b1;
        state  <= SHIFT;
      end else begin
        case (state)
          SHIFT: begin
            out    <= (out & ~bit_mask)    | (cell_d    ? bit_mask : '0);
            borrow <= (borrow & ~bit_mask) | (cell_bout ? bit_mask : '0);
            bin    <= cell_bout;
            op1    <= op1 >> 1;
            op2    <= op2 >> 1;
            idx    <= idx + CNT_W'(1);
            if (last_bit) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          IDLE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
